// File: rtl/apb_master_bridge.sv
// APB requester: turns single-outstanding command/response requests into
// SETUP/ACCESS transfers, with pready wait states and an optional wait timeout.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Wait counter never wraps, even when the timeout is disabled.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB completer with programmable wait states,
// plus a memory/timeout reference model predicting every response.
module tb_apb_master_bridge;

  localparam int TMO = 4;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready;

  int checks = 0;
  int failures = 0;

  // Completer side
  logic [31:0] mem [0:255];
  int          stall_cfg = 0;   // low-pready cycles before ready; negative = never ready
  int          wcnt;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  // Reference model
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rd;
  logic        last_err;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  assign pready = psel && penable && (stall_cfg >= 0) && (wcnt >= stall_cfg);
  assign prdata = ovr_en ? ovr_val : mem[paddr[7:0]];

  always @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      wcnt <= 0;
    end else begin
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr[7:0]] <= pwdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    last_rd  = 32'h0;
    last_err = 1'b0;
  endtask

  // One complete transfer, started at a negedge while the bridge is idle.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input int stall);
    int          acc_cycles;
    int          exp_cycles;
    bit          exp_err;
    logic [31:0] exp_rd;
    exp_err    = (stall < 0) || (stall >= TMO);
    exp_cycles = exp_err ? TMO : stall + 1;
    exp_rd     = (wr || exp_err) ? 32'h0 : (ovr_en ? ovr_val : ref_mem[a]);
    if (wr && !exp_err) ref_mem[a] = d;
    stall_cfg = stall;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = {24'h0, a}; cmd_wdata = d;
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, {24'h0, a});
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, d);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("rsp_rdata_hold", rsp_rdata, last_rd);
    chk("rsp_err_hold", rsp_err, last_err);
    @(negedge pclk);
    acc_cycles = 0;
    do begin
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, {24'h0, a});
      chk("access_pwrite", pwrite, wr);
      chk("access_pwdata", pwdata, d);
      acc_cycles++;
      @(negedge pclk);
    end while (!rsp_valid && acc_cycles < 40);
    chk("rsp_valid", rsp_valid, 1);
    chk("access_len", acc_cycles, exp_cycles);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("done_psel", psel, 0);
    chk("done_penable", penable, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    last_rd  = exp_rd;
    last_err = exp_err;
  endtask

  initial begin
    int nacc, nresp, last_acc, seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge pclk);

    xfer(1'b0, 8'd5, 32'h1234_5678, 0);
    xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 8'h10, 32'h0BAD_F00D, 0);

    ovr_en = 1'b1; ovr_val = 32'hA5A5_A5A5;
    xfer(1'b0, 8'd7, 32'h0, 3);
    ovr_en = 1'b0;

    xfer(1'b0, 8'd20, 32'h0, -1);
    chk("to_next_psel", psel, 0);
    xfer(1'b0, 8'd3, 32'h0, 0);
    xfer(1'b1, 8'd30, 32'hCAFE_0001, -1);
    xfer(1'b0, 8'd30, 32'h0, 0);

    // cmd_valid held high across three reads
    stall_cfg = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd1;
    nacc = 0; nresp = 0; last_acc = -1;
    for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
      bit acc;
      acc = cmd_valid && cmd_ready;
      @(negedge pclk);
      if (acc) begin
        if (nacc > 0) chk("b2b_gap", cyc - last_acc, 3);
        last_acc = cyc;
        nacc++;
        if (nacc < 3) cmd_addr = 32'(nacc + 1);
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        chk("b2b_rdata", rsp_rdata, ref_mem[nresp + 1]);
        chk("b2b_err", rsp_err, 0);
        nresp++;
      end
    end
    chk("b2b_accepts", nacc, 3);
    chk("b2b_responses", nresp, 3);
    @(negedge pclk);
    chk("b2b_no_extra", psel, 0);
    last_rd = ref_mem[3]; last_err = 1'b0;

    for (int i = 0; i < 24; i++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
           int'($urandom_range(0, 5)));
      if ($urandom_range(0, 1) == 1) @(negedge pclk);
    end

    // Reset while the completer stalls in ACCESS
    stall_cfg = -1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd9;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("pre_rst_penable", penable, 1);
    rst = 1'b1;
    @(negedge pclk);
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    model_reset();
    stall_cfg = 0;
    seen = 0;
    repeat (8) begin
      @(negedge pclk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    xfer(1'b0, 8'd3, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
